hilo_controlador: RTL and testbench
===================================

Name: hilo_controlador

Overview:
- Sequential owner of the HI/LO register pair and the driver side of the combinational multiply/divide coprocessor.
- Accepts operation requests from the CPU datapath over a valid/ready handshake and registers the operands.
- Drives the coprocessor (op code, operands, current HI/LO) stable for a fixed settling window, then commits the coprocessor's hi/lo results.
- Also serves MTHI/MTLO writes and continuous MFHI/MFLO reads.

Parameters:
- LATENCIA, 2, number of EXEC cycles the coprocessor inputs are held before its outputs are captured (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  3  000 mult, 001 madd, 010 msub, 011 div, 100 MTHI, 101 MTLO, 110/111 illegal.
- req_a  input  32  operand A (dividend / MTHI-MTLO data).
- req_b  input  32  operand B (divisor).
- cop_op  output  3  op code to the coprocessor.
- cop_a  output  32  coprocessor Entrada_01.
- cop_b  output  32  coprocessor Entrada_02.
- cop_hi_in  output  32  current HI to the coprocessor.
- cop_lo_in  output  32  current LO to the coprocessor.
- cop_hi_out  input  32  coprocessor HI result.
- cop_lo_out  input  32  coprocessor LO result.
- hi  output  32  architectural HI (MFHI).
- lo  output  32  architectural LO (MFLO).
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  qualifies done: division by zero, not executed.
- erro  output  1  qualifies done: illegal op, ignored.

Behaviour:
- Reset (asynchronous, any state, including mid-EXEC):
  - State returns to IDLE.
  - hi, lo, cop_a, cop_b and the EXEC counter clear to 0.
  - cop_op clears to 000.
  - done, div_zero and erro clear to 0.
  - Any in-flight operation is discarded; nothing is committed.
- States: IDLE, EXEC.
- req_ready is 1 exactly when the state is IDLE. A request is accepted at a rising edge where req_valid and req_ready are both 1.
- Accept in IDLE, op 000/001/010, or op 011 with req_b != 0:
  - Latch req_op, req_a and req_b into cop_op, cop_a and cop_b.
  - Load the counter with LATENCIA-1 and go to EXEC.
- Accept op 011 with req_b == 0:
  - Stay in IDLE; hi and lo are unchanged.
  - Next cycle: done=1 and div_zero=1.
- Accept op 100 (MTHI): hi <= req_a at the accepting edge; done=1 next cycle.
- Accept op 101 (MTLO): lo <= req_a at the accepting edge; done=1 next cycle.
- Accept op 110/111: no state change; next cycle done=1 and erro=1.
- EXEC:
  - cop_op, cop_a, cop_b, cop_hi_in and cop_lo_in are held constant.
  - cop_hi_in and cop_lo_in are always the hi and lo registers.
  - The counter decrements each edge.
  - At the edge where the counter equals 0: hi <= cop_hi_out, lo <= cop_lo_out, state returns to IDLE, and done=1 for the following cycle.
- Timing:
  - Accept at edge E0 gives commit at edge E_LATENCIA; the new hi/lo and done are visible in the cycle after E_LATENCIA.
  - The earliest next accept is edge E_(LATENCIA+1), so throughput is one coprocessor op per LATENCIA+1 cycles.
  - MTHI/MTLO sustain one per cycle.
- done, div_zero and erro are registered single-cycle pulses; div_zero and erro are 0 whenever done is 0.
- req_a, req_b and req_op changes while the state is not IDLE are ignored.
- hi and lo change only at a commit, an MTHI/MTLO, or reset.
- No arithmetic is done here. madd/msub accumulation uses the coprocessor result committed as-is; 64-bit wrap-around is the coprocessor's responsibility.

Test Plan:
- Reset, then mult 3 x 0xFFFFFFFE (-2) with LATENCIA=2 -> req_ready low for 2 cycles; hi=0xFFFFFFFF and lo=0xFFFFFFFA with done=1 in cycle 3 after accept.
- MTHI 0, MTLO 10 on consecutive cycles, then madd 4 x 5 -> done pulses after each MT*; cop_hi_in=0 and cop_lo_in=10 during EXEC; final hi=0, lo=30.
- div 100 / 7 -> lo=14, hi=2; then div 5 / 0 -> done=1, div_zero=1 next cycle, hi=2 and lo=14 unchanged, no EXEC cycle.
- msub 2 x 3 from hi=0, lo=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; req_a/req_b toggled during EXEC must not alter cop_a/cop_b.
- Assert reset in the middle of a mult EXEC (hi=lo=0x55 beforehand) -> immediate IDLE, hi=lo=0, no done pulse; a fresh request is accepted on the first edge after reset release.
- req_op=110 -> done=1, erro=1 for one cycle, hi/lo unchanged; back-to-back valid requests show acceptance only when req_ready=1.

Source files
------------

// File: rtl/hilo_controlador_if.sv
// -----------------------------------------------------------------------------
// hilo_controlador_if
//
// Bundles every non-clock/reset signal of the HI/LO controller: the CPU request
// handshake, the drive/capture lines of the combinational mult/div coprocessor,
// the architectural HI/LO read-out and the completion flags.
//
//   req_valid / req_ready     : request handshake (accept when both are 1)
//   req_op[2:0]               : 000 mult, 001 madd, 010 msub, 011 div,
//                               100 MTHI, 101 MTLO, 110/111 illegal
//   req_a, req_b [31:0]       : operands (req_a is also MTHI/MTLO data)
//   cop_op, cop_a, cop_b      : operation held towards the coprocessor
//   cop_hi_in, cop_lo_in      : current HI/LO fed to the coprocessor
//   cop_hi_out, cop_lo_out    : coprocessor results
//   hi, lo                    : architectural HI/LO (MFHI/MFLO)
//   done, div_zero, erro      : one-cycle completion pulse and its qualifiers
//
// Modports:
//   slave  - the controller
//   master - the CPU datapath plus coprocessor side (or a testbench)
// -----------------------------------------------------------------------------
interface hilo_controlador_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  cop_op;
  logic [31:0] cop_a;
  logic [31:0] cop_b;
  logic [31:0] cop_hi_in;
  logic [31:0] cop_lo_in;
  logic [31:0] cop_hi_out;
  logic [31:0] cop_lo_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_zero;
  logic        erro;

  modport slave (
    input  req_valid, req_op, req_a, req_b, cop_hi_out, cop_lo_out,
    output req_ready, cop_op, cop_a, cop_b, cop_hi_in, cop_lo_in,
           hi, lo, done, div_zero, erro
  );

  modport master (
    output req_valid, req_op, req_a, req_b, cop_hi_out, cop_lo_out,
    input  req_ready, cop_op, cop_a, cop_b, cop_hi_in, cop_lo_in,
           hi, lo, done, div_zero, erro
  );
endinterface

// File: rtl/hilo_controlador.sv
// -----------------------------------------------------------------------------
// hilo_controlador
//
// Owns the HI/LO register pair and drives the combinational multiply/divide
// coprocessor. A request accepted in IDLE either completes immediately
// (MTHI, MTLO, divide-by-zero, illegal op) or starts an EXEC window of
// LATENCIA cycles during which the coprocessor inputs are frozen; at the end
// of the window the coprocessor hi/lo results are committed as-is.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high; discards any in-flight operation
//   bus    - hilo_controlador_if.slave (request handshake, coprocessor
//            drive/capture, HI/LO read-out, done/div_zero/erro pulses)
//
// Parameter:
//   LATENCIA - EXEC cycles the coprocessor inputs are held (1..15)
// -----------------------------------------------------------------------------
module hilo_controlador #(
  parameter int unsigned LATENCIA = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  hilo_controlador_if.slave     bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // Counter is loaded with LATENCIA-1 so that the commit edge is exactly
  // LATENCIA edges after the accepting edge.
  localparam logic [3:0] CNT_INIT = 4'(LATENCIA - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_div_zero;
  logic        r_erro;

  logic        w_accept;
  logic        w_start;
  logic        w_commit;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // Only ops that really need the coprocessor open an EXEC window; a divide
  // by zero is answered straight from IDLE.
  assign w_start  = w_accept &&
                    ((bus.req_op <= 3'b010) ||
                     ((bus.req_op == 3'b011) && (bus.req_b != 32'd0)));

  assign w_commit = (r_state == S_EXEC) && (r_cnt == 4'd0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start)  w_state_next = S_EXEC;
      S_EXEC: if (w_commit) w_state_next = S_IDLE;
      default:              w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand latches, EXEC counter, HI/LO and completion pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_op       <= 3'b000;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses by default.
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_erro     <= 1'b0;

      if (w_start) begin
        r_op  <= bus.req_op;
        r_a   <= bus.req_a;
        r_b   <= bus.req_b;
        r_cnt <= CNT_INIT;
      end else if (w_accept) begin
        case (bus.req_op)
          3'b011: begin
            // Only reachable with req_b == 0: refuse, leave HI/LO alone.
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end
          3'b100: begin
            r_hi   <= bus.req_a;
            r_done <= 1'b1;
          end
          3'b101: begin
            r_lo   <= bus.req_a;
            r_done <= 1'b1;
          end
          default: begin
            r_done <= 1'b1;
            r_erro <= 1'b1;
          end
        endcase
      end else if (r_state == S_EXEC) begin
        if (r_cnt == 4'd0) begin
          r_hi   <= bus.cop_hi_out;
          r_lo   <= bus.cop_lo_out;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.cop_op    = r_op;
    bus.cop_a     = r_a;
    bus.cop_b     = r_b;
    // The coprocessor always sees the architectural HI/LO; they cannot move
    // during EXEC because no other request is accepted there.
    bus.cop_hi_in = r_hi;
    bus.cop_lo_in = r_lo;
    bus.hi        = r_hi;
    bus.lo        = r_lo;
    bus.done      = r_done;
    bus.div_zero  = r_div_zero;
    bus.erro      = r_erro;
  end

endmodule

// File: tb/tb_hilo_controlador.sv
// -----------------------------------------------------------------------------
// tb_hilo_controlador
//
// Drives the controller through its request interface, stands in for the
// combinational coprocessor with a behavioural 64-bit signed mult/div model,
// and checks HI/LO, handshake and completion pulses against a transaction
// level model of the HI/LO registers.
// -----------------------------------------------------------------------------
module tb_hilo_controlador;

  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  hilo_controlador_if bus ();

  hilo_controlador #(.LATENCIA(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected architectural HI/LO.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Result {hi,lo} of an operation on signed 32-bit operands.
  function automatic logic [63:0] copro(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = 64'(sa * sb);
    acc = {hi, lo};
    case (op)
      3'b000: return p;
      3'b001: return acc + p;
      3'b010: return acc - p;
      3'b011: begin
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  // Stand-in for the combinational coprocessor.
  assign {bus.cop_hi_out, bus.cop_lo_out} =
      copro(bus.cop_op, bus.cop_a, bus.cop_b, bus.cop_hi_in, bus.cop_lo_in);

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'hFFFFFFFF - 32'($urandom_range(0, 20));
      2:       return ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request at a negedge while IDLE, then watch until done.
  // lat = cycle (1 = right after the accepting edge) where done was seen,
  // 0 if it never came. Snapshots the coprocessor drive right after accept
  // and flags any later change before done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, output int lat, output int rdy_low,
                        output bit hold_bad, output bit dz, output bit er,
                        output logic [31:0] s_a, output logic [31:0] s_b,
                        output logic [31:0] s_hi, output logic [31:0] s_lo);
    logic [2:0] s_op;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    bus.req_valid = 1'b0;
    lat = 0; rdy_low = 0; hold_bad = 1'b0; dz = 1'b0; er = 1'b0;
    s_op = bus.cop_op; s_a = bus.cop_a; s_b = bus.cop_b;
    s_hi = bus.cop_hi_in; s_lo = bus.cop_lo_in;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        lat = c; dz = bus.div_zero; er = bus.erro;
        break;
      end
      if (bus.req_ready !== 1'b1) rdy_low++;
      if ({bus.cop_op, bus.cop_a, bus.cop_b, bus.cop_hi_in, bus.cop_lo_in} !==
          {s_op, s_a, s_b, s_hi, s_lo}) hold_bad = 1'b1;
      if (toggle) begin
        // Noise on the request lines while busy must be ignored.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d dz=%0b er=%0b",
             op, a, b, bus.hi, bus.lo, lat, dz, er);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_op = 3'b000; bus.req_a = 32'd0; bus.req_b = 32'd0;
    #2 reset = 1'b1;
    #1;  // before any clock edge: clearing must be asynchronous
    n_vec++;
    if ({bus.req_ready, bus.done, bus.div_zero, bus.erro} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 1000",
               {bus.req_ready, bus.done, bus.div_zero, bus.erro});
    end
    n_vec++;
    if ({bus.hi, bus.lo, bus.cop_a, bus.cop_b, bus.cop_op} !== 131'd0) begin
      n_err++;
      $display("FAIL reset_regs: hi=%h lo=%h a=%h b=%h op=%h, want all 0",
               bus.hi, bus.lo, bus.cop_a, bus.cop_b, bus.cop_op);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    run_op(3'b000, 32'd3, 32'hFFFFFFFE, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (lat !== LAT + 1 || rl !== LAT) begin
      n_err++;
      $display("FAIL mult_timing: lat=%0d ready_low=%0d want %0d/%0d", lat, rl, LAT + 1, LAT);
    end
    n_vec++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFA || dz !== 1'b0 || er !== 1'b0) begin
      n_err++;
      $display("FAIL mult_result: hi=%h lo=%h dz=%b er=%b want FFFFFFFF FFFFFFFA 0 0",
               bus.hi, bus.lo, dz, er);
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
  endtask

  task automatic test_mt_madd();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    run_op(3'b100, 32'd0, $urandom, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (lat !== 1 || bus.hi !== 32'd0 || bus.lo !== m_lo) begin
      n_err++;
      $display("FAIL mthi: lat=%0d hi=%h lo=%h want 1 0 %h", lat, bus.hi, bus.lo, m_lo);
    end
    run_op(3'b101, 32'd10, $urandom, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (lat !== 1 || bus.hi !== 32'd0 || bus.lo !== 32'd10) begin
      n_err++;
      $display("FAIL mtlo: lat=%0d hi=%h lo=%h want 1 0 a", lat, bus.hi, bus.lo);
    end
    run_op(3'b001, 32'd4, 32'd5, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (sh !== 32'd0 || sl !== 32'd10 || hb !== 1'b0) begin
      n_err++;
      $display("FAIL madd_cop_in: hi_in=%h lo_in=%h changed=%b want 0 a 0", sh, sl, hb);
    end
    n_vec++;
    if (lat !== LAT + 1 || bus.hi !== 32'd0 || bus.lo !== 32'd30) begin
      n_err++;
      $display("FAIL madd_result: lat=%0d hi=%h lo=%h want %0d 0 1e", lat, bus.hi, bus.lo, LAT + 1);
    end
    m_hi = 32'd0; m_lo = 32'd30;
  endtask

  task automatic test_div();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    run_op(3'b011, 32'd100, 32'd7, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (lat !== LAT + 1 || bus.hi !== 32'd2 || bus.lo !== 32'd14 || dz !== 1'b0) begin
      n_err++;
      $display("FAIL div_result: lat=%0d hi=%h lo=%h dz=%b want %0d 2 e 0",
               lat, bus.hi, bus.lo, dz, LAT + 1);
    end
    run_op(3'b011, 32'd5, 32'd0, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (lat !== 1 || rl !== 0 || dz !== 1'b1 || er !== 1'b0) begin
      n_err++;
      $display("FAIL div_zero_flags: lat=%0d ready_low=%0d dz=%b er=%b want 1 0 1 0",
               lat, rl, dz, er);
    end
    n_vec++;
    if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
      n_err++;
      $display("FAIL div_zero_keep: hi=%h lo=%h want 2 e", bus.hi, bus.lo);
    end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_msub_hold();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    run_op(3'b100, 32'd0, 32'd0, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    run_op(3'b101, 32'd1, 32'd0, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    run_op(3'b010, 32'd2, 32'd3, 1'b1, lat, rl, hb, dz, er, sa, sb, sh, sl);
    n_vec++;
    if (hb !== 1'b0 || sa !== 32'd2 || sb !== 32'd3) begin
      n_err++;
      $display("FAIL msub_hold: changed=%b cop_a=%h cop_b=%h want 0 2 3", hb, sa, sb);
    end
    n_vec++;
    if (lat !== LAT + 1 || {bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFB) begin
      n_err++;
      $display("FAIL msub_result: lat=%0d hi=%h lo=%h want %0d FFFFFFFF FFFFFFFB",
               lat, bus.hi, bus.lo, LAT + 1);
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFB;
  endtask

  task automatic test_reset_mid_exec();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    run_op(3'b100, 32'h55, 32'd0, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    run_op(3'b101, 32'h55, 32'd0, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_a = 32'd7; bus.req_b = 32'd9;
    tick();
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.req_ready !== 1'b0 || bus.cop_a !== 32'd7) begin
      n_err++;
      $display("FAIL rst_exec_start: ready=%b cop_a=%h want 0 7", bus.req_ready, bus.cop_a);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.req_ready, bus.done, bus.hi, bus.lo, bus.cop_a, bus.cop_op} !== {2'b10, 99'd0}) begin
      n_err++;
      $display("FAIL rst_exec_clear: ready=%b done=%b hi=%h lo=%h cop_a=%h op=%h want 1 0 0 0 0 0",
               bus.req_ready, bus.done, bus.hi, bus.lo, bus.cop_a, bus.cop_op);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_err++;
      $display("FAIL rst_exec_nodone: done=%b hi=%h lo=%h want 0 0 0", bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 3'b100; bus.req_a = 32'h77;
    tick();
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.done !== 1'b1 || bus.hi !== 32'h77 || bus.lo !== 32'd0) begin
      n_err++;
      $display("FAIL rst_exec_fresh: done=%b hi=%h lo=%h want 1 77 0", bus.done, bus.hi, bus.lo);
    end
    m_hi = 32'h77; m_lo = 32'd0;
  endtask

  task automatic test_illegal();
    int lat, rl; bit hb, dz, er; logic [31:0] sa, sb, sh, sl;
    for (int k = 6; k <= 7; k++) begin
      run_op(3'(k), $urandom, $urandom, 1'b0, lat, rl, hb, dz, er, sa, sb, sh, sl);
      n_vec++;
      if (lat !== 1 || er !== 1'b1 || dz !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_err++;
        $display("FAIL illegal_%0d: lat=%0d er=%b dz=%b hi=%h lo=%h want 1 1 0 %h %h",
                 k, lat, er, dz, bus.hi, bus.lo, m_hi, m_lo);
      end
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.erro !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_pulse_%0d: done=%b erro=%b want 0 0", k, bus.done, bus.erro);
      end
    end
  endtask

  // Free-running request stream checked cycle by cycle against the model.
  // The model tracks only how many busy cycles remain after an accepted
  // coprocessor op and which completion is due next.
  task automatic stream(input int n, input bit always_valid, input string tag);
    int remain = 0;
    bit p_done = 1'b0, p_dz = 1'b0, p_er = 1'b0, v;
    logic [2:0] f_op = 3'b000, op;
    logic [31:0] f_a = 32'd0, f_b = 32'd0, a, b;
    int txn = 0;
    bus.req_valid = 1'b0;
    tick();  // let any earlier completion pulse drain
    for (int c = 0; c < n || remain > 0; c++) begin
      n_vec++;
      if ({bus.req_ready, bus.done, bus.div_zero, bus.erro} !== {remain == 0, p_done, p_dz, p_er}) begin
        n_err++;
        $display("FAIL %s_flags cyc %0d: ready/done/dz/er=%b want %b", tag, c,
                 {bus.req_ready, bus.done, bus.div_zero, bus.erro},
                 {remain == 0, p_done, p_dz, p_er});
      end
      n_vec++;
      if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin
        n_err++;
        $display("FAIL %s_hilo cyc %0d: hi=%h lo=%h want %h %h", tag, c, bus.hi, bus.lo, m_hi, m_lo);
      end
      if (remain > 0) begin
        n_vec++;
        if ({bus.cop_op, bus.cop_a, bus.cop_b, bus.cop_hi_in, bus.cop_lo_in} !==
            {f_op, f_a, f_b, m_hi, m_lo}) begin
          n_err++;
          $display("FAIL %s_cop cyc %0d: op=%h a=%h b=%h hi_in=%h lo_in=%h want %h %h %h %h %h",
                   tag, c, bus.cop_op, bus.cop_a, bus.cop_b, bus.cop_hi_in, bus.cop_lo_in,
                   f_op, f_a, f_b, m_hi, m_lo);
        end
      end
      v  = (c < n) && (always_valid || $urandom_range(0, 2) != 0);
      op = 3'($urandom);
      a  = rand_val();
      b  = (op == 3'b011 && $urandom_range(0, 2) == 0) ? 32'd0 : rand_val();
      bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      @(posedge clk);
      p_done = 1'b0; p_dz = 1'b0; p_er = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          {m_hi, m_lo} = copro(f_op, f_a, f_b, m_hi, m_lo);
          p_done = 1'b1;
        end
      end else if (v) begin
        txn++;
        if (op <= 3'b010 || (op == 3'b011 && b != 32'd0)) begin
          f_op = op; f_a = a; f_b = b; remain = LAT;
        end else if (op == 3'b011) begin
          p_done = 1'b1; p_dz = 1'b1;
        end else if (op == 3'b100) begin
          m_hi = a; p_done = 1'b1;
        end else if (op == 3'b101) begin
          m_lo = a; p_done = 1'b1;
        end else begin
          p_done = 1'b1; p_er = 1'b1;
        end
        $display("txn %s #%0d op=%0d a=%h b=%h", tag, txn, op, a, b);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    stream(80, 1'b1, "b2b");
  endtask

  task automatic test_random();
    stream(300, 1'b0, "rand");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mt_madd();
    test_div();
    test_msub_hold();
    test_reset_mid_exec();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
